// File: rtl/aes_key_expand.sv
// On-the-fly AES-128 key schedule: loads a cipher key, then streams round keys
// 0..NUM_ROUNDS one per handshake, using an external combinational S-box lane.
module aes_key_expand #(
   parameter int NUM_ROUNDS = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         key_valid,
   output logic         key_ready,
   input  logic [127:0] key_in,
   output logic         rk_valid,
   input  logic         rk_ready,
   output logic [127:0] round_key,
   output logic [3:0]   rk_round,
   output logic         rk_last,
   output logic [31:0]  sbox_in,
   input  logic [31:0]  sbox_out
);

   typedef enum logic {
      IDLE,
      EMIT
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [7:0]  rcon;
   logic [7:0]  rcon_next;
   logic        accept;
   logic        advance;
   logic        finish;
   logic [31:0] w0, w1, w2, w3;
   logic [31:0] n0, n1, n2, n3;

   assign key_ready = (state == IDLE);
   assign rk_valid  = (state == EMIT);
   assign rk_last   = rk_valid && (rk_round == 4'(NUM_ROUNDS));

   assign accept  = key_valid && key_ready;
   assign advance = rk_valid && rk_ready && !rk_last;
   assign finish  = rk_valid && rk_ready && rk_last;

   assign w0 = round_key[127:96];
   assign w1 = round_key[95:64];
   assign w2 = round_key[63:32];
   assign w3 = round_key[31:0];

   // RotWord of the last word goes out to the shared S-box lane; the lane
   // answers in the same cycle, so the next key is ready combinationally.
   assign sbox_in = {w3[23:0], w3[31:24]};

   assign n0 = w0 ^ sbox_out ^ {rcon, 24'h000000};
   assign n1 = w1 ^ n0;
   assign n2 = w2 ^ n1;
   assign n3 = w3 ^ n2;

   assign rcon_next = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = EMIT;
         EMIT:    if (finish) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Key, round index and rcon only move on a load or an accepted
   // non-final key, so backpressure holds them bit-stable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         round_key <= '0;
         rk_round  <= '0;
         rcon      <= 8'h01;
      end else if (accept) begin
         round_key <= key_in;
         rk_round  <= '0;
         rcon      <= 8'h01;
      end else if (advance) begin
         round_key <= {n0, n1, n2, n3};
         rk_round  <= rk_round + 4'd1;
         rcon      <= rcon_next;
      end
   end

endmodule
